scan_sequencer: RTL and testbench
=================================

Name: scan_sequencer

Overview:
- Upstream stage of the 3-to-8 select decoder in the 8-digit display path.
- Holds a 32-bit, 8-nibble display word and steps a 3-bit digit index at a prescaled rate.
- Drives the decoder select lines a2,a1,a0 and presents the nibble for the selected digit.
- Skips masked-off digits and applies new data only at frame boundaries, so a frame never mixes old and new digits.

Parameters:
- DIV, 100000, clk cycles per digit step (100 MHz -> 1 kHz/digit); legal range 2..2^20.
- CNT_W, $clog2(DIV), prescaler width (derived; never overridden).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  1 = prescaler runs; 0 = freeze prescaler and index.
- load  input  1  one-cycle strobe; capture din.
- din  input  32  display word; nibble k = din[4k+3:4k].
- mask  input  8  per-digit enable; bit k = 1 shows digit k.
- a2  output  1  select code MSB to decoder.
- a1  output  1  select code bit 1.
- a0  output  1  select code LSB.
- nibble  output  4  data of the currently selected digit.
- blank  output  1  1 = no digit is to be lit.
- frame_done  output  1  one-cycle pulse when the index wraps.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - cnt=0, idx=0, {a2,a1,a0}=000, shown=0, pending=0, pend=0.
  - started=0, blank=1, nibble=0, frame_done=0.
  - Reset mid-frame discards pending data.
- Prescaler:
  - While en=1, cnt counts 0..DIV-1 and wraps to 0.
  - tick = en & (cnt==DIV-1).
  - en=0 holds cnt, idx and all outputs; load is still accepted.
- Index step on tick (mask sampled that cycle), in priority order:
  - mask==0: idx holds, blank=1, no frame_done, started unchanged.
  - started=0: idx = lowest set mask bit; started=1; no frame_done.
  - A set mask bit exists above idx: idx = the smallest such bit.
  - Otherwise (wrap): idx = lowest set mask bit; frame_done=1 for exactly that cycle.
  - A single enabled digit wraps onto itself every tick, so frame_done pulses every tick.
- Data:
  - load=1: pending<=din, pend<=1.
  - On a wrap tick: if load=1 in the same cycle, shown<=din (newest wins); else if pend, shown<=pending. pend<=0 in both cases.
  - While started=0, shown tracks load directly, with no boundary wait.
- Outputs:
  - All outputs are registered and change on the edge after the tick cycle; latency is 1 clk from tick.
  - {a2,a1,a0}=idx.
  - nibble=shown[4*idx+3:4*idx], taking the shown value that is in effect after the update.
  - blank = ~started | ~mask[idx_new] | (mask==0).
  - Outside tick cycles, blank also re-evaluates every cycle against the live mask, so clearing the current digit's bit blanks it next cycle.
- Boundaries:
  - idx arithmetic is modulo 8.
  - A mask change mid-frame takes effect at the next tick.
  - Simultaneous load and wrap follow the data rules above.
  - Back-to-back loads keep only the last value.

Decomposition:
- Shared package (disp_pkg):
  - NDIG=8, IDX_W=3, NIB_W=4.
  - Function next_enabled(mask, idx, started), returning {wrap, idx_next}.
- One natural sub-module: scan_prescaler (cnt, tick output, en input).
- Index/data logic stays in scan_sequencer.

Test Plan (DIV=4):
- Reset then mask=FF, en=1, load din=3210_7654 in the first cycle:
  - First tick gives idx=0, nibble=4.
  - Following ticks every 4 clks give nibble 5,6,7,0,1,2,3.
  - frame_done pulses on the 7->0 transition.
- mask=0x51 (digits 0,4,6):
  - idx sequence 0,4,6,0,4,6.
  - frame_done on each 6->0 transition; a2a1a0 = 000,100,110.
- load din=AAAA_AAAA mid-frame (idx=3, old word 0):
  - Digits 4..7 still show 0.
  - After the wrap, every nibble shows A; pend clears.
- load asserted in the same cycle as the wrap tick, with an earlier pending value 1111_1111 and din=2222_2222:
  - shown=2222_2222; the 1s are never displayed.
- mask=0 after running:
  - blank=1 the next cycle; idx frozen; no frame_done.
  - Then mask=0x80: next tick gives idx=7 and blank=0.
- en=0 for 10 clks at cnt=2:
  - Outputs and cnt frozen.
  - rst_n=0 for one clk mid-frame returns all reset values; pending is lost.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and helpers for the 8-digit display scan path.
package disp_pkg;

   localparam int unsigned NDIG   = 8;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned NIB_W  = 4;
   localparam int unsigned WORD_W = NDIG * NIB_W;

   typedef logic [IDX_W-1:0]  idx_t;
   typedef logic [NDIG-1:0]   mask_t;
   typedef logic [NIB_W-1:0]  nib_t;
   typedef logic [WORD_W-1:0] word_t;

   typedef struct packed {
      logic wrap;
      idx_t idx_next;
   } step_t;

   // Next enabled digit: first step lands on the lowest digit, later steps
   // move to the smallest enabled digit above idx, else wrap to the lowest.
   function automatic step_t next_enabled(input mask_t mask, input idx_t idx,
                                          input logic started);
      step_t r;
      idx_t  low;
      idx_t  up;
      logic  found_up;
      low      = '0;
      up       = '0;
      found_up = 1'b0;
      for (int i = NDIG - 1; i >= 0; i--) begin
         if (mask[i]) begin
            low = IDX_W'(i);
            if (i > int'(idx)) begin
               up       = IDX_W'(i);
               found_up = 1'b1;
            end
         end
      end
      if (!started) begin
         r.wrap     = 1'b0;
         r.idx_next = low;
      end else if (found_up) begin
         r.wrap     = 1'b0;
         r.idx_next = up;
      end else begin
         r.wrap     = 1'b1;
         r.idx_next = low;
      end
      return r;
   endfunction

   // Nibble k of a display word.
   function automatic nib_t sel_nibble(input word_t w, input idx_t i);
      return w[{i, 2'b00} +: NIB_W];
   endfunction

endpackage

// File: rtl/scan_sequencer_if.sv
// Control inputs and decoder-side outputs of the scan sequencer.
interface scan_sequencer_if;
   import disp_pkg::*;

   logic  en;
   logic  load;
   word_t din;
   mask_t mask;
   logic  a2;
   logic  a1;
   logic  a0;
   nib_t  nibble;
   logic  blank;
   logic  frame_done;

   modport master (
      output en, load, din, mask,
      input  a2, a1, a0, nibble, blank, frame_done
   );

   modport slave (
      input  en, load, din, mask,
      output a2, a1, a0, nibble, blank, frame_done
   );

endinterface

// File: rtl/scan_prescaler.sv
// Digit-step prescaler: pulses tick_c once every DIV enabled clocks.
module scan_prescaler #(
   parameter int unsigned DIV = 100000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick_c
);

   localparam int unsigned CNT_W = $clog2(DIV);

   logic [CNT_W-1:0] cnt;
   logic             last_c;

   assign last_c = (cnt == CNT_W'(DIV - 1));
   assign tick_c = en & last_c;

   // Count 0..DIV-1 while enabled, hold otherwise
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= last_c ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/scan_sequencer.sv
// Digit scan sequencer feeding the 3-to-8 select decoder of the display.
module scan_sequencer
   import disp_pkg::*;
#(
   parameter int unsigned DIV = 100000
) (
   input  logic              clk,
   input  logic              rst_n,
   scan_sequencer_if.slave   bus
);

   logic  tick_c;
   logic  mask_any_c;
   logic  step_c;
   logic  wrap_c;
   step_t nxt_c;
   word_t shown_nx_c;

   idx_t  idx;
   word_t shown;
   word_t pending;
   logic  pend;
   logic  started;
   nib_t  nibble_q;
   logic  blank_q;
   logic  frame_done_q;

   scan_prescaler #(.DIV(DIV)) u_prescaler (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (bus.en),
      .tick_c (tick_c)
   );

   assign mask_any_c = |bus.mask;
   assign step_c     = tick_c & mask_any_c;
   assign nxt_c      = next_enabled(bus.mask, idx, started);

   // Displayed word after this cycle: swapped only at a frame wrap, or
   // followed directly before the first step
   always_comb begin
      wrap_c     = step_c & started & nxt_c.wrap;
      shown_nx_c = shown;
      if (wrap_c) begin
         if (bus.load) begin
            shown_nx_c = bus.din;
         end else if (pend) begin
            shown_nx_c = pending;
         end
      end else if (!started && bus.load) begin
         shown_nx_c = bus.din;
      end
   end

   // Index, data buffers and registered decoder outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx          <= '0;
         shown        <= '0;
         pending      <= '0;
         pend         <= 1'b0;
         started      <= 1'b0;
         nibble_q     <= '0;
         blank_q      <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= wrap_c;
         shown        <= shown_nx_c;
         if (bus.load) begin
            pending <= bus.din;
         end
         if (wrap_c) begin
            pend <= 1'b0;
         end else if (bus.load) begin
            pend <= 1'b1;
         end
         if (step_c) begin
            idx      <= nxt_c.idx_next;
            started  <= 1'b1;
            nibble_q <= sel_nibble(shown_nx_c, nxt_c.idx_next);
            blank_q  <= ~bus.mask[nxt_c.idx_next];
         end else begin
            blank_q  <= ~started | ~bus.mask[idx] | ~mask_any_c;
         end
      end
   end

   assign {bus.a2, bus.a1, bus.a0} = idx;
   assign bus.nibble               = nibble_q;
   assign bus.blank                = blank_q;
   assign bus.frame_done           = frame_done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer with DIV=4 (one digit step every 4 clocks).
module tb_scan_sequencer;
   import disp_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   scan_sequencer_if bus();

   scan_sequencer #(.DIV(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Observed output bundle {a2,a1,a0,nibble,blank,frame_done}
   function automatic logic [8:0] obs();
      return {bus.a2, bus.a1, bus.a0, bus.nibble, bus.blank, bus.frame_done};
   endfunction

   function automatic logic [8:0] ev(input int i, input int n, input logic b, input logic f);
      return {3'(i), 4'(n), b, f};
   endfunction

   // Advance n clocks; inputs change and outputs are sampled 1 time unit after the edge
   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      bus.en   = 1'b0;
      bus.load = 1'b0;
      bus.din  = '0;
      bus.mask = '0;
      step(2);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [8:0] e;
      rst_n    = 1'b0;
      bus.en   = 1'b1;
      bus.load = 1'b0;
      bus.din  = '0;
      bus.mask = 8'hFF;
      step(2);
      e = ev(0, 0, 1'b1, 1'b0);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected %b", obs(), e);
      end
      checks++;
      if (dut.pend !== 1'b0) begin
         errors++;
         $display("FAIL reset_pend: got %b expected 0", dut.pend);
      end
   endtask

   task automatic test_full_scan();
      logic [8:0] e;
      logic [3:0] nibs [8] = '{4'h4, 4'h5, 4'h6, 4'h7, 4'h0, 4'h1, 4'h2, 4'h3};
      do_reset();
      bus.en   = 1'b1;
      bus.mask = 8'hFF;
      bus.load = 1'b1;
      bus.din  = 32'h3210_7654;
      step(1);
      bus.load = 1'b0;
      step(2);
      e = ev(0, 0, 1'b1, 1'b0);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL pre_start_blank: got %b expected %b", obs(), e);
      end
      step(1);
      e = ev(0, 4, 1'b0, 1'b0);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL first_tick: got %b expected %b", obs(), e);
      end
      for (int k = 1; k <= 8; k++) begin
         step(4);
         e = ev(k % 8, nibs[k % 8], 1'b0, (k == 8));
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL full_scan_step%0d: got %b expected %b", k, obs(), e);
         end
      end
      step(1);
      checks++;
      if (bus.frame_done !== 1'b0) begin
         errors++;
         $display("FAIL frame_done_one_cycle: got %b expected 0", bus.frame_done);
      end
   endtask

   task automatic test_mask_skip();
      logic [8:0] e;
      int seq [6] = '{4, 6, 0, 4, 6, 0};
      do_reset();
      bus.en   = 1'b1;
      bus.mask = 8'h51;
      bus.load = 1'b1;
      bus.din  = 32'h7654_3210;
      step(1);
      bus.load = 1'b0;
      step(3);
      e = ev(0, 0, 1'b0, 1'b0);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL mask_first: got %b expected %b", obs(), e);
      end
      for (int k = 0; k < 6; k++) begin
         step(4);
         e = ev(seq[k], seq[k], 1'b0, (seq[k] == 0));
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL mask_skip_step%0d: got %b expected %b", k, obs(), e);
         end
      end
   endtask

   task automatic test_midframe_load();
      logic [8:0] e;
      do_reset();
      bus.en   = 1'b1;
      bus.mask = 8'hFF;
      step(4);
      step(12);
      e = ev(3, 0, 1'b0, 1'b0);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL midload_idx3: got %b expected %b", obs(), e);
      end
      step(1);
      bus.load = 1'b1;
      bus.din  = 32'hAAAA_AAAA;
      step(1);
      bus.load = 1'b0;
      checks++;
      if (dut.pend !== 1'b1) begin
         errors++;
         $display("FAIL midload_pend_set: got %b expected 1", dut.pend);
      end
      step(2);
      for (int k = 4; k <= 7; k++) begin
         if (k > 4) step(4);
         e = ev(k, 0, 1'b0, 1'b0);
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL midload_old_digit%0d: got %b expected %b", k, obs(), e);
         end
      end
      step(4);
      e = ev(0, 4'hA, 1'b0, 1'b1);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL midload_wrap: got %b expected %b", obs(), e);
      end
      checks++;
      if (dut.pend !== 1'b0) begin
         errors++;
         $display("FAIL midload_pend_clear: got %b expected 0", dut.pend);
      end
      step(4);
      e = ev(1, 4'hA, 1'b0, 1'b0);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL midload_new_digit1: got %b expected %b", obs(), e);
      end
   endtask

   task automatic test_load_on_wrap();
      logic [8:0] e;
      do_reset();
      bus.en   = 1'b1;
      bus.mask = 8'hFF;
      step(4);
      step(28);
      e = ev(7, 0, 1'b0, 1'b0);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL wrapload_idx7: got %b expected %b", obs(), e);
      end
      bus.load = 1'b1;
      bus.din  = 32'h1111_1111;
      step(1);
      bus.load = 1'b0;
      step(2);
      bus.load = 1'b1;
      bus.din  = 32'h2222_2222;
      step(1);
      bus.load = 1'b0;
      e = ev(0, 2, 1'b0, 1'b1);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL wrapload_newest: got %b expected %b", obs(), e);
      end
      for (int k = 1; k <= 7; k++) begin
         step(4);
         e = ev(k, 2, 1'b0, 1'b0);
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL wrapload_digit%0d: got %b expected %b", k, obs(), e);
         end
      end
   endtask

   task automatic test_mask_zero();
      logic [8:0] e;
      do_reset();
      bus.en   = 1'b1;
      bus.mask = 8'hFF;
      bus.load = 1'b1;
      bus.din  = 32'h7654_3210;
      step(1);
      bus.load = 1'b0;
      step(3);
      step(4);
      e = ev(1, 1, 1'b0, 1'b0);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL mask0_running: got %b expected %b", obs(), e);
      end
      bus.mask = 8'h00;
      step(1);
      e = ev(1, 1, 1'b1, 1'b0);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL mask0_blank_next: got %b expected %b", obs(), e);
      end
      for (int k = 0; k < 2; k++) begin
         step(k == 0 ? 3 : 4);
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL mask0_frozen_tick%0d: got %b expected %b", k, obs(), e);
         end
      end
      bus.mask = 8'h80;
      step(1);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL mask80_before_tick: got %b expected %b", obs(), e);
      end
      step(3);
      e = ev(7, 7, 1'b0, 1'b0);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL mask80_first: got %b expected %b", obs(), e);
      end
      for (int k = 0; k < 2; k++) begin
         step(4);
         e = ev(7, 7, 1'b0, 1'b1);
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL single_digit_wrap%0d: got %b expected %b", k, obs(), e);
         end
      end
   endtask

   task automatic test_enable_freeze();
      logic [8:0] e;
      do_reset();
      bus.en   = 1'b1;
      bus.mask = 8'hFF;
      bus.load = 1'b1;
      bus.din  = 32'h7654_3210;
      step(1);
      bus.load = 1'b0;
      step(3);
      step(2);
      bus.en = 1'b0;
      e = ev(0, 0, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         step(1);
         if (k % 3 == 0 || k == 9) begin
            checks++;
            if (obs() !== e) begin
               errors++;
               $display("FAIL freeze_clk%0d: got %b expected %b", k, obs(), e);
            end
         end
      end
      bus.en = 1'b1;
      step(1);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL resume_cnt_held: got %b expected %b", obs(), e);
      end
      step(1);
      e = ev(1, 1, 1'b0, 1'b0);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL resume_tick: got %b expected %b", obs(), e);
      end
   endtask

   task automatic test_reset_midframe();
      logic [8:0] e;
      bus.load = 1'b1;
      bus.din  = 32'hFFFF_FFFF;
      step(1);
      bus.load = 1'b0;
      checks++;
      if (dut.pend !== 1'b1) begin
         errors++;
         $display("FAIL midreset_pend_set: got %b expected 1", dut.pend);
      end
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      e = ev(0, 0, 1'b1, 1'b0);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL midreset_outputs: got %b expected %b", obs(), e);
      end
      checks++;
      if (dut.pend !== 1'b0) begin
         errors++;
         $display("FAIL midreset_pend: got %b expected 0", dut.pend);
      end
      step(4);
      e = ev(0, 0, 1'b0, 1'b0);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL midreset_first_tick: got %b expected %b", obs(), e);
      end
      step(32);
      e = ev(0, 0, 1'b0, 1'b1);
      checks++;
      if (obs() !== e) begin
         errors++;
         $display("FAIL midreset_pending_lost: got %b expected %b", obs(), e);
      end
   endtask

   initial begin
      test_reset();
      test_full_scan();
      test_mask_skip();
      test_midframe_load();
      test_load_on_wrap();
      test_mask_zero();
      test_enable_freeze();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
